// File: rtl/in_order_inst_queue_pkg.sv
// rtl/in_order_inst_queue_pkg.sv - shared widths, entry struct and helpers for the instruction queue
// Purpose: constants and the packed per-instruction entry used by every queue file.
// Ports: none (package).
package in_order_inst_queue_pkg;

    localparam int ADDRESS_WIDTH          = 64;
    localparam int INSTRUCTION_WIDTH      = 32;  // raw instruction width, informational only
    localparam int PID_SIZE               = 32;
    localparam int TID_SIZE               = 64;
    localparam int INST_COUNTER_WIDTH     = 64;
    localparam int INST_MIN_ID_WIDTH      = 5;
    localparam int PRIM_OPCODE_SIZE       = 6;   // informational only
    localparam int OPCODE_SIZE            = 12;
    localparam int REG_SIZE               = 5;   // informational only
    localparam int REG_ACCESS_SIZE        = 2;
    localparam int FUNC_UNIT_CODE_SIZE    = 3;
    localparam int FORMAT_WIDTH           = 25;
    localparam int BODY_WIDTH             = 64;
    localparam int QUEUE_INDEX_WIDTH      = 10;
    localparam int NUM_QUEUE_ENTRIES      = 2 ** QUEUE_INDEX_WIDTH;
    localparam int COUNT_WIDTH            = QUEUE_INDEX_WIDTH + 1;
    localparam int NUM_SLOTS              = 4;

    // Bit positions inside an operand access-pattern field.
    localparam int REG_ACCESS_READ_BIT    = 0;
    localparam int REG_ACCESS_WRITE_BIT   = 1;

    typedef struct packed {
        logic [FORMAT_WIDTH-1:0]                    format;
        logic [OPCODE_SIZE-1:0]                     opcode;
        logic [ADDRESS_WIDTH-1:0]                   address;
        logic [FUNC_UNIT_CODE_SIZE-1:0]             func_unit;
        logic [INST_COUNTER_WIDTH-1:0]              maj_id;
        logic [INST_MIN_ID_WIDTH-1:0]               min_id;
        logic [INST_MIN_ID_WIDTH-1:0]               num_uops;
        logic                                       is_64bit;
        logic [PID_SIZE-1:0]                        pid;
        logic [TID_SIZE-1:0]                        tid;
        logic [3:0][REG_ACCESS_SIZE-1:0]            op_rw;
        logic [3:0]                                 op_is_reg;
        logic                                       modifies_cr;
        logic [BODY_WIDTH-1:0]                      body;
    } inst_entry_t;

    function automatic logic [2:0] count_enables(input logic [3:0] en);
        return 3'(en[0]) + 3'(en[1]) + 3'(en[2]) + 3'(en[3]);
    endfunction

endpackage

// File: rtl/in_order_inst_queue_if.sv
// rtl/in_order_inst_queue_if.sv - decoder-side enqueue and backend-side dequeue bundle
// Purpose: groups the 4-wide enqueue slots, dequeue request/response and status.
// Signals: inst_en/inst (4 slots in), read_enable (in), output_enable, num_instructions_out,
//          inst_out (4 slots), head, tail, is_empty, is_full (out of the queue).
interface in_order_inst_queue_if;
    import in_order_inst_queue_pkg::*;

    logic [NUM_SLOTS-1:0]                   inst_en;
    inst_entry_t [NUM_SLOTS-1:0]            inst;
    logic                                   read_enable;
    logic                                   output_enable;
    logic [1:0]                             num_instructions_out;
    inst_entry_t [NUM_SLOTS-1:0]            inst_out;
    logic [QUEUE_INDEX_WIDTH-1:0]           head;
    logic [QUEUE_INDEX_WIDTH-1:0]           tail;
    logic                                   is_empty;
    logic                                   is_full;

    modport master (
        output inst_en, inst, read_enable,
        input  output_enable, num_instructions_out, inst_out, head, tail, is_empty, is_full
    );

    modport slave (
        input  inst_en, inst, read_enable,
        output output_enable, num_instructions_out, inst_out, head, tail, is_empty, is_full
    );
endinterface

// File: rtl/in_order_inst_queue_store.sv
// rtl/in_order_inst_queue_store.sv - 4-write/4-read entry array addressed by pointer+offset
// Purpose: queue storage; write port j lands at wr_ptr+j, read port k returns rd_ptr+k.
// Ports: clock_i; wr_en/wr_data (4 compacted write ports), wr_ptr; rd_ptr, rd_data (4 async reads).
module inst_queue_store
    import in_order_inst_queue_pkg::*;
(
    input  logic                            clock_i,
    input  logic [NUM_SLOTS-1:0]            wr_en,
    input  logic [QUEUE_INDEX_WIDTH-1:0]    wr_ptr,
    input  inst_entry_t [NUM_SLOTS-1:0]     wr_data,
    input  logic [QUEUE_INDEX_WIDTH-1:0]    rd_ptr,
    output inst_entry_t [NUM_SLOTS-1:0]     rd_data
);

    // Contents are don't-care after reset, so the array carries no reset.
    inst_entry_t mem [NUM_QUEUE_ENTRIES];

    always_ff @(posedge clock_i) begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (wr_en[j]) begin
                mem[wr_ptr + QUEUE_INDEX_WIDTH'(j)] <= wr_data[j];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            rd_data[k] = mem[rd_ptr + QUEUE_INDEX_WIDTH'(k)];
        end
    end

endmodule

// File: rtl/in_order_inst_queue.sv
// rtl/in_order_inst_queue.sv - 4-wide in-order circular instruction queue
// Purpose: enqueues up to 4 decoded micro-ops per cycle in program order and dequeues up to
//          4 of the oldest on request, with registered outputs and status flags.
// Ports: clock_i, reset_i (async, active-high); bus (slave side of in_order_inst_queue_if).
module in_order_inst_queue
    import in_order_inst_queue_pkg::*;
(
    input  logic                    clock_i,
    input  logic                    reset_i,
    in_order_inst_queue_if.slave    bus
);

    logic [QUEUE_INDEX_WIDTH-1:0]   head;
    logic [QUEUE_INDEX_WIDTH-1:0]   tail;
    logic [COUNT_WIDTH-1:0]         count;
    logic [COUNT_WIDTH-1:0]         count_next;
    logic [COUNT_WIDTH-1:0]         free_slots;
    logic [2:0]                     n_en;
    logic [2:0]                     n_wr;
    logic [2:0]                     n_rd;
    logic                           accept;
    logic [1:0]                     idx;
    logic [NUM_SLOTS-1:0]           wr_en;
    inst_entry_t [NUM_SLOTS-1:0]    wr_data;
    inst_entry_t [NUM_SLOTS-1:0]    rd_data;

    logic                           output_enable;
    logic [1:0]                     num_out;
    inst_entry_t [NUM_SLOTS-1:0]    inst_out;
    logic                           is_empty;
    logic                           is_full;

    inst_queue_store u_store (
        .clock_i (clock_i),
        .wr_en   (wr_en),
        .wr_ptr  (tail),
        .wr_data (wr_data),
        .rd_ptr  (head),
        .rd_data (rd_data)
    );

    always_comb begin
        n_en    = count_enables(bus.inst_en);
        wr_data = '0;
        idx     = '0;
        // Pack enabled slots down onto consecutive write ports, preserving slot order.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.inst_en[i]) begin
                wr_data[idx] = bus.inst[i];
                idx          = idx + 2'd1;
            end
        end

        if (bus.read_enable && count != '0) begin
            n_rd = (count >= COUNT_WIDTH'(NUM_SLOTS)) ? 3'd4 : count[2:0];
        end else begin
            n_rd = 3'd0;
        end

        // Entries being read this edge are available to the same edge's write group.
        free_slots = COUNT_WIDTH'(NUM_QUEUE_ENTRIES) - count + COUNT_WIDTH'(n_rd);
        accept     = COUNT_WIDTH'(n_en) <= free_slots;
        n_wr       = accept ? n_en : 3'd0;

        for (int j = 0; j < NUM_SLOTS; j++) begin
            wr_en[j] = 3'(j) < n_wr;
        end

        count_next = count + COUNT_WIDTH'(n_wr) - COUNT_WIDTH'(n_rd);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            output_enable <= 1'b0;
            num_out       <= 2'd0;
            inst_out      <= '0;
            is_empty      <= 1'b1;
            is_full       <= 1'b0;
        end else begin
            head          <= head + QUEUE_INDEX_WIDTH'(n_rd);
            tail          <= tail + QUEUE_INDEX_WIDTH'(n_wr);
            count         <= count_next;
            output_enable <= n_rd != 3'd0;
            num_out       <= (n_rd != 3'd0) ? 2'(n_rd - 3'd1) : 2'd0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                inst_out[k] <= (3'(k) < n_rd) ? rd_data[k] : '0;
            end
            is_empty      <= count_next == '0;
            // Full means a 4-wide group can no longer be guaranteed a place.
            is_full       <= count_next > COUNT_WIDTH'(NUM_QUEUE_ENTRIES - NUM_SLOTS);
        end
    end

    assign bus.output_enable        = output_enable;
    assign bus.num_instructions_out = num_out;
    assign bus.inst_out             = inst_out;
    assign bus.head                 = head;
    assign bus.tail                 = tail;
    assign bus.is_empty             = is_empty;
    assign bus.is_full              = is_full;

endmodule

// File: tb/tb_in_order_inst_queue.sv
// tb/tb_in_order_inst_queue.sv - randomized bench for in_order_inst_queue against a queue model
module tb_in_order_inst_queue;
    import in_order_inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    inst_entry_t model_q [$];
    int          head_m = 0;
    int          tail_m = 0;
    logic        exp_oe = 1'b0;
    logic [1:0]  exp_num = 2'd0;
    inst_entry_t exp_out [4];

    in_order_inst_queue_if bus ();

    in_order_inst_queue dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic inst_entry_t rand_entry(input int maj, input int addr);
        inst_entry_t e;
        e.format      = 25'(1) << $urandom_range(0, 24);
        e.opcode      = 12'($urandom);
        e.address     = 64'(addr);
        e.func_unit   = 3'($urandom);
        e.maj_id      = 64'(maj);
        e.min_id      = 5'($urandom);
        e.num_uops    = 5'd1;
        e.is_64bit    = 1'($urandom);
        e.pid         = $urandom;
        e.tid         = {$urandom, $urandom};
        e.op_rw       = 8'($urandom);
        e.op_is_reg   = 4'($urandom);
        e.modifies_cr = 1'($urandom);
        e.body        = {$urandom, $urandom};
        return e;
    endfunction

    task automatic check_outputs();
        check("output_enable", 512'(bus.output_enable), 512'(exp_oe));
        check("num_out", 512'(bus.num_instructions_out), 512'(exp_num));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("slot%0d", k + 1), 512'(bus.inst_out[k]), 512'(exp_out[k]));
        end
        check("head", 512'(bus.head), 512'(head_m));
        check("tail", 512'(bus.tail), 512'(tail_m));
        check("is_empty", 512'(bus.is_empty), 512'(model_q.size() == 0));
        check("is_full", 512'(bus.is_full), 512'(model_q.size() > 1020));
    endtask

    // Drive one cycle with bus.inst already loaded, update the model, then compare.
    task automatic do_cycle(input logic [3:0] en, input logic re);
        int r;
        int e;
        bus.inst_en     = en;
        bus.read_enable = re;
        r = re ? ((model_q.size() < 4) ? model_q.size() : 4) : 0;
        for (int k = 0; k < 4; k++) begin
            exp_out[k] = (k < r) ? model_q.pop_front() : '0;
        end
        exp_oe  = r != 0;
        exp_num = (r != 0) ? 2'(r - 1) : 2'd0;
        head_m  = (head_m + r) % 1024;
        e = $countones(en);
        if (e <= 1024 - model_q.size()) begin
            for (int i = 0; i < 4; i++) begin
                if (en[i]) model_q.push_back(bus.inst[i]);
            end
            tail_m = (tail_m + e) % 1024;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic load_random();
        for (int i = 0; i < 4; i++) begin
            bus.inst[i] = rand_entry($urandom, $urandom);
        end
    endtask

    int saved_tail;

    initial begin
        bus.inst_en     = '0;
        bus.read_enable = 1'b0;
        bus.inst        = '0;
        for (int k = 0; k < 4; k++) exp_out[k] = '0;
        #12;
        check("reset_tail", 512'(bus.tail), 512'(0));
        check("reset_head", 512'(bus.head), 512'(0));
        check("reset_empty", 512'(bus.is_empty), 512'(1));
        check("reset_oe", 512'(bus.output_enable), 512'(0));
        check("reset_full", 512'(bus.is_full), 512'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) bus.inst[i] = rand_entry(i, 4 * i);
        do_cycle(4'hF, 1'b0);
        check("tail_after_4", 512'(bus.tail), 512'(4));
        bus.inst = '0;
        do_cycle(4'h0, 1'b0);
        check("idle_tail", 512'(bus.tail), 512'(4));
        check("idle_empty", 512'(bus.is_empty), 512'(0));
        bus.inst[0] = rand_entry(4, 16);
        do_cycle(4'h1, 1'b0);
        check("tail_after_1", 512'(bus.tail), 512'(5));
        do_cycle(4'h0, 1'b1);
        check("read4_num", 512'(bus.num_instructions_out), 512'(3));
        for (int k = 0; k < 4; k++) begin
            check("read4_maj", 512'(bus.inst_out[k].maj_id), 512'(k));
            check("read4_addr", 512'(bus.inst_out[k].address), 512'(4 * k));
        end
        check("read4_head", 512'(bus.head), 512'(4));
        do_cycle(4'h0, 1'b1);
        check("read1_num", 512'(bus.num_instructions_out), 512'(0));
        check("read1_maj", 512'(bus.inst_out[0].maj_id), 512'(4));
        check("read1_addr", 512'(bus.inst_out[0].address), 512'(16));
        check("read1_head", 512'(bus.head), 512'(5));
        check("read1_empty", 512'(bus.is_empty), 512'(1));
        do_cycle(4'h0, 1'b1);
        check("read_empty_oe", 512'(bus.output_enable), 512'(0));

        // Fill to 1020, then one more to 1021 which sets full.
        for (int c = 0; c < 255; c++) begin
            load_random();
            do_cycle(4'hF, 1'b0);
        end
        check("fill_1020_full", 512'(bus.is_full), 512'(0));
        load_random();
        do_cycle(4'h1, 1'b0);
        check("fill_1021_full", 512'(bus.is_full), 512'(1));
        saved_tail = int'(bus.tail);
        load_random();
        do_cycle(4'hF, 1'b0);
        check("drop_tail", 512'(bus.tail), 512'(saved_tail));

        // Steady 4-in/4-out at 1021 entries, wrapping both pointers.
        for (int c = 0; c < 300; c++) begin
            load_random();
            do_cycle(4'hF, 1'b1);
        end
        check("steady_count", 512'(model_q.size()), 512'(1021));
        check("steady_full", 512'(bus.is_full), 512'(1));

        // Random mix, read-biased first to drain, then balanced.
        for (int c = 0; c < 2000; c++) begin
            load_random();
            do_cycle(4'($urandom), ($urandom_range(0, 99) < ((c < 600) ? 85 : 50)));
        end

        // Asynchronous reset mid-operation.
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        head_m = 0;
        tail_m = 0;
        exp_oe = 1'b0;
        exp_num = 2'd0;
        for (int k = 0; k < 4; k++) exp_out[k] = '0;
        check_outputs();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
